// File: rtl/add_result_fifo.sv
// add_result_fifo
//   Result buffer placed directly after adder64. Every sum presented with
//   in_rdy is captured into a first-word fall-through FIFO and held until the
//   consumer takes it over a valid/ready handshake. Overflowing results are
//   dropped, and the bench-visible ovf/drop_cnt pair records that they were lost.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_sum     result from adder64 (LEN_DATA bits)
//   in_rdy     in_sum is written when high at a clock edge
//   out_data   head-of-FIFO result, 0 when empty
//   out_valid  out_data holds a valid entry
//   out_ready  consumer accepts out_data this cycle
//   count      occupied entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   ovf        sticky: at least one result dropped since reset or clear
//   drop_cnt   dropped results, saturating at 16'hFFFF
//   ovf_clr    synchronous clear of ovf and drop_cnt
module add_result_fifo #(
  parameter int LEN_DATA = 64,
  parameter int DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LEN_DATA-1:0]       in_sum,
  input  logic                      in_rdy,
  output logic [LEN_DATA-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      ovf,
  output logic [15:0]               drop_cnt,
  input  logic                      ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [LEN_DATA-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count_nxt;

  logic push;
  logic pop;
  logic drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign pop  = ~empty & out_ready;
  assign push = in_rdy & (~full | pop);
  assign drop = in_rdy & full & ~pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !push) count_nxt = count - (AW+1)'(1);
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      // Flags come from the same next-count so they never disagree with count.
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // The clear takes priority over a drop occurring in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_add_result_fifo.sv
module tb_add_result_fifo;

  logic        clk;
  logic        rst;
  logic [63:0] in_sum;
  logic        in_rdy;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic        ovf_clr;

  int n_cmp;
  int n_fail;

  add_result_fifo #(.LEN_DATA(64), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sum    (in_sum),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] seq2 [6];
    n_cmp  = 0;
    n_fail = 0;
    seq2[0] = 64'd977;  seq2[1] = 64'd833; seq2[2] = 64'd130;
    seq2[3] = 64'd1455; seq2[4] = 64'd129; seq2[5] = 64'd96447;

    // 1: reset
    rst = 1'b0; in_sum = '0; in_rdy = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    #20;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    #14 rst = 1'b1;
    step();
    chk("rel_empty", 64'(empty), 64'd1);
    chk("rel_ovf", 64'(ovf), 64'd0);
    chk("rel_full", 64'(full), 64'd0);

    // 2: six pushes then drain in order
    in_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_sum = seq2[i];
      step();
      if (i == 0) begin
        chk("t2_lat_valid", 64'(out_valid), 64'd1);
        chk("t2_lat_data", out_data, 64'd977);
      end
    end
    in_rdy = 1'b0;
    chk("t2_count", 64'(count), 64'd6);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t2_data", out_data, seq2[i]);
      step();
    end
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_data_empty", out_data, 64'd0);
    out_ready = 1'b0;

    // 3: overflow with 1..10
    in_rdy = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      in_sum = 64'(v);
      step();
    end
    in_rdy = 1'b0;
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      chk("t3_drain", out_data, 64'(v));
      step();
    end
    out_ready = 1'b0;
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_ovf_hold", 64'(ovf), 64'd1);

    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    // 4: full FIFO streaming through pointer wrap
    in_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sum = 64'(101 + i);
      step();
    end
    chk("t4_full", 64'(full), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_sum = 64'(109 + i);
      chk("t4_head", out_data, 64'(101 + i));
      step();
      chk("t4_count", 64'(count), 64'd8);
    end
    in_rdy = 1'b0;
    out_ready = 1'b0;
    chk("t4_drop", 64'(drop_cnt), 64'd0);
    chk("t4_ovf", 64'(ovf), 64'd0);
    chk("t4_head_end", out_data, 64'd121);

    // 5: async reset with count=5 during a push
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    chk("t5_count5", 64'(count), 64'd5);
    chk("t5_head", out_data, 64'd124);
    in_rdy = 1'b1;
    in_sum = 64'd999;
    #3 rst = 1'b0;
    #1;
    chk("t5_async_count", 64'(count), 64'd0);
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_data", out_data, 64'd0);
    in_rdy = 1'b0;
    step();
    step();
    chk("t5_hold_empty", 64'(empty), 64'd1);
    #3 rst = 1'b1;
    step();
    chk("t5_rel_empty", 64'(empty), 64'd1);
    in_rdy = 1'b1;
    in_sum = 64'd65;
    step();
    in_rdy = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_data", out_data, 64'd65);
    chk("t5_count1", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_empty", 64'(empty), 64'd1);

    // 6: clear wins over drop, then saturation
    in_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sum = 64'(200 + i);
      step();
    end
    chk("t6_full", 64'(full), 64'd1);
    in_sum = 64'hDEAD;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t6_clr_ovf", 64'(ovf), 64'd0);
    chk("t6_clr_drop", 64'(drop_cnt), 64'd0);
    repeat (100) step();
    chk("t6_drop100", 64'(drop_cnt), 64'd100);
    chk("t6_ovf", 64'(ovf), 64'd1);
    repeat (69900) step();
    chk("t6_sat", 64'(drop_cnt), 64'hFFFF);
    in_rdy = 1'b0;
    chk("t6_count", 64'(count), 64'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t6_drain", out_data, 64'(200 + i));
      step();
    end
    out_ready = 1'b0;
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_sat_hold", 64'(drop_cnt), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
